// File: rtl/regfile_sequencer_pkg.sv
// Shared encodings for the four-register sequencer: opcodes, instruction
// field positions, ALU op codes, FSM states and decoded op classes.
package regfile_sequencer_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_HALT
  } op_class_t;

endpackage

// File: rtl/regfile_sequencer_instr_decoder.sv
// Combinational split of the instruction register into register indices,
// immediate, op class and ALU op; undefined opcodes decode as NOP + illegal.
module regfile_sequencer_instr_decoder
  import regfile_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  rd,
  output logic [1:0]  rs1,
  output logic [1:0]  rs2,
  output logic [5:0]  imm,
  output op_class_t   op_class,
  output logic [1:0]  alu_op,
  output logic        illegal
);

  logic [3:0] op;

  assign op  = ir[OP_HI:OP_LO];
  assign rd  = ir[RD_HI:RD_LO];
  assign rs1 = ir[RS1_HI:RS1_LO];
  assign rs2 = ir[RS2_HI:RS2_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    case (op)
      OP_NOP: op_class = CLS_NOP;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        op_class = CLS_ALU;
        // Opcodes 1..4 map onto ALU codes 0..3.
        alu_op   = 2'(op - 4'd1);
      end
      OP_LOAD:  op_class = CLS_LOAD;
      OP_STORE: op_class = CLS_STORE;
      OP_HALT:  op_class = CLS_HALT;
      default:  illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM: fetch over req/ack, decode, launch ALU or data-memory
// handshake, then at most one register-file write per instruction.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              instr_req,
  input  logic              instr_ack,
  input  logic [15:0]       instr_in,
  output logic [PC_W-1:0]   pc,
  output logic [1:0]        rf_read_idx1,
  output logic [1:0]        rf_read_idx2,
  output logic [1:0]        rf_write_idx,
  output logic              rf_write_en,
  output logic              wb_sel,
  output logic [1:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  state_t      state;
  logic [15:0] ir;
  logic [1:0]  dec_rd;
  logic [1:0]  dec_rs1;
  logic [1:0]  dec_rs2;
  logic [5:0]  dec_imm;
  op_class_t   dec_class;
  logic [1:0]  dec_alu_op;
  logic        dec_illegal;

  regfile_sequencer_instr_decoder u_decoder (
    .ir       (ir),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .illegal  (dec_illegal)
  );

  // Indices come straight from IR, which only changes as FETCH hands over to
  // DECODE, so they are valid in DECODE and hold until the next one.
  assign rf_read_idx1 = dec_rs1;
  assign rf_read_idx2 = dec_rs2;
  assign rf_write_idx = dec_rd;
  assign alu_op       = dec_alu_op;
  assign mem_addr     = ADDR_W'(dec_imm);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      pc          <= '0;
      instr_req   <= 1'b0;
      rf_write_en <= 1'b0;
      wb_sel      <= 1'b0;
      alu_start   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      alu_start   <= 1'b0;
      rf_write_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            instr_req <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (instr_ack) begin
            ir        <= instr_in;
            pc        <= pc + PC_W'(1);
            instr_req <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) illegal <= 1'b1;
          case (dec_class)
            CLS_ALU: begin
              state     <= ST_EXEC;
              alu_start <= 1'b1;
            end
            CLS_LOAD, CLS_STORE: begin
              state   <= ST_MEM;
              mem_req <= 1'b1;
              mem_we  <= (dec_class == CLS_STORE);
            end
            CLS_HALT: begin
              state  <= ST_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: begin
              state     <= ST_FETCH;
              instr_req <= 1'b1;
            end
          endcase
        end
        ST_EXEC: begin
          // alu_done is accepted even in the cycle alu_start is high.
          if (alu_done) begin
            state       <= ST_WB;
            rf_write_en <= 1'b1;
            wb_sel      <= 1'b0;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (dec_class == CLS_LOAD) begin
              state       <= ST_WB;
              rf_write_en <= 1'b1;
              wb_sel      <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              instr_req <= 1'b1;
            end
          end
        end
        ST_WB: begin
          state     <= ST_FETCH;
          instr_req <= 1'b1;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
